// File: rtl/seg7_display_arbiter.sv
// Fixed-priority owner arbiter for the shared 4-digit seven-segment display.
// src2 (message) > src1 (alarm/set) > src0 (time). A minimum hold time keeps
// the display from flickering between owners. A src2 owner blinks its value.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no source owns the display, IDLE_VAL shown
// OWN0  | time-of-day source owns the display
// OWN1  | alarm/set-mode source owns the display
// OWN2  | message source owns the display, blinking
module seg7_display_arbiter #(
    parameter int unsigned HOLD_CYCLES  = 50_000_000,
    parameter int unsigned BLINK_CYCLES = 25_000_000,
    parameter logic [15:0] IDLE_VAL     = 16'h0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [2:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    output logic [2:0]  gnt,
    output logic [1:0]  disp_src,
    output logic [15:0] x,
    output logic        disp_on
);

    // A parameter value of 1 would give a zero-width counter, so floor at 1 bit.
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    // Encoding order doubles as priority order: a larger value outranks a smaller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        OWN2 = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    state_t          hp;
    logic            owner_req;
    logic [HW-1:0]   hold_cnt;
    logic [BW-1:0]   blink_cnt;
    logic [2:0]      gnt_nxt;
    logic [1:0]      src_nxt;
    logic [15:0]     x_nxt;

    // Highest-priority requester and whether the current owner still requests.
    always_comb begin
        hp = IDLE;
        if (req[2])      hp = OWN2;
        else if (req[1]) hp = OWN1;
        else if (req[0]) hp = OWN0;

        owner_req = 1'b0;
        case (state)
            OWN0:    owner_req = req[0];
            OWN1:    owner_req = req[1];
            OWN2:    owner_req = req[2];
            default: owner_req = 1'b0;
        endcase
    end

    // Next owner: a dropped request hands over at once; preemption waits for hold.
    always_comb begin
        state_nxt = state;
        if (state == IDLE || !owner_req) begin
            state_nxt = hp;
        end else if (hp > state && hold_cnt == '0) begin
            state_nxt = hp;
        end
    end

    // Output values for the next owner, so grant and data change together.
    always_comb begin
        gnt_nxt = 3'b000;
        src_nxt = 2'd3;
        x_nxt   = IDLE_VAL;
        case (state_nxt)
            OWN0: begin gnt_nxt = 3'b001; src_nxt = 2'd0; x_nxt = val0; end
            OWN1: begin gnt_nxt = 3'b010; src_nxt = 2'd1; x_nxt = val1; end
            OWN2: begin gnt_nxt = 3'b100; src_nxt = 2'd2; x_nxt = val2; end
            default: begin gnt_nxt = 3'b000; src_nxt = 2'd3; x_nxt = IDLE_VAL; end
        endcase
    end

    // Owner state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    // Hold counter: reloaded on every grant into a new owner, then runs down to 0.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hold_cnt <= '0;
        end else if (state_nxt != state && state_nxt != IDLE) begin
            hold_cnt <= HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end

    // Blink phase for src2; every other owner shows steady segments.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            blink_cnt <= '0;
            disp_on   <= 1'b1;
        end else if (state_nxt == OWN2 && state == OWN2) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                disp_on   <= ~disp_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end else begin
            blink_cnt <= '0;
            disp_on   <= 1'b1;
        end
    end

    // Registered grant, owner index and display value.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            gnt      <= 3'b000;
            disp_src <= 2'd3;
            x        <= IDLE_VAL;
        end else begin
            gnt      <= gnt_nxt;
            disp_src <= src_nxt;
            x        <= x_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with short hold and blink periods.
module tb_seg7_display_arbiter;

    logic        clk;
    logic        clr;
    logic [2:0]  req;
    logic [15:0] val0;
    logic [15:0] val1;
    logic [15:0] val2;
    logic [2:0]  gnt;
    logic [1:0]  disp_src;
    logic [15:0] x;
    logic        disp_on;

    int checks;
    int errors;

    seg7_display_arbiter #(
        .HOLD_CYCLES  (8),
        .BLINK_CYCLES (4),
        .IDLE_VAL     (16'h0000)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .req      (req),
        .val0     (val0),
        .val1     (val1),
        .val2     (val2),
        .gnt      (gnt),
        .disp_src (disp_src),
        .x        (x),
        .disp_on  (disp_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs at once against an expected owner view.
    task automatic check_all(input string tag, input logic [2:0] e_gnt, input logic [1:0] e_src,
                             input logic [15:0] e_x, input logic e_on);
        check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        check({tag, ".src"}, 32'(disp_src), 32'(e_src));
        check({tag, ".x"}, 32'(x), 32'(e_x));
        check({tag, ".on"}, 32'(disp_on), 32'(e_on));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr  = 1'b1;
        req  = 3'b000;
        val0 = 16'h1234;
        val1 = 16'h5A5A;
        val2 = 16'hEEEE;

        tick();
        tick();
        check_all("reset", 3'b000, 2'd3, 16'h0000, 1'b1);
        clr = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            check_all("idle", 3'b000, 2'd3, 16'h0000, 1'b1);
        end

        // Basic grant of src0 at edge t, data follows live.
        req = 3'b001;
        tick();
        check_all("grant0", 3'b001, 2'd0, 16'h1234, 1'b1);
        val0 = 16'h1235;
        tick();
        check("live_x", 32'(x), 32'h1235);

        // src2 raised at t+2 must wait for hold; src1 joins later and is outranked.
        tick();
        req = 3'b101;
        for (int e = 3; e <= 7; e++) begin
            tick();
            check("hold_gnt", 32'(gnt), 32'b001);
            check("hold_x", 32'(x), 32'h1235);
            if (e == 5) req = 3'b111;
        end
        tick();
        check_all("preempt2", 3'b100, 2'd2, 16'hEEEE, 1'b1);

        // Blink with half-period 4 while src1 keeps requesting underneath.
        for (int i = 1; i < 20; i++) begin
            tick();
            check("blink_gnt", 32'(gnt), 32'b100);
            check("blink_on", 32'(disp_on), ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
        end

        // src2 releases: src1 takes over, segments steady in the same cycle.
        req = 3'b011;
        tick();
        check_all("release2", 3'b010, 2'd1, 16'h5A5A, 1'b1);

        // src1 drops during its hold: src0 takes over immediately.
        tick();
        req = 3'b001;
        tick();
        check_all("drop1", 3'b001, 2'd0, 16'h1235, 1'b1);

        // Owner drops and re-asserts alone: one idle cycle, then re-grant.
        req = 3'b000;
        tick();
        check_all("regrant_idle", 3'b000, 2'd3, 16'h0000, 1'b1);
        req = 3'b001;
        tick();
        check_all("regrant0", 3'b001, 2'd0, 16'h1235, 1'b1);

        // Get src2 into its blink off-phase via idle, then reset asynchronously.
        req = 3'b000;
        tick();
        req = 3'b100;
        val2 = 16'hC0DE;
        tick();
        check_all("own2", 3'b100, 2'd2, 16'hC0DE, 1'b1);
        for (int i = 1; i <= 4; i++) tick();
        check("offphase", 32'(disp_on), 32'd0);
        #2;
        clr = 1'b1;
        #1;
        check_all("async_clr", 3'b000, 2'd3, 16'h0000, 1'b1);
        tick();
        check_all("clr_held", 3'b000, 2'd3, 16'h0000, 1'b1);
        #2;
        clr = 1'b0;
        tick();
        check_all("fresh2", 3'b100, 2'd2, 16'hC0DE, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("fresh_blink", 32'(disp_on), (i < 4) ? 32'd1 : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_display_arbiter.md
Name: seg7_display_arbiter

Overview:
- Shares the single 4-digit seven-segment display between three value producers in the digital clock: time-of-day (src0), alarm/set-mode value (src1) and a transient message/status source (src2).
- Fixed-priority selection, src2 > src1 > src0, with preemption by a higher-priority source.
- A minimum-hold counter prevents display flicker between owners.
- Drives the 16-bit hex value and a blank/blink enable into the seven-segment scan/decoder downstream.

Parameters:
- HOLD_CYCLES, 50_000_000, minimum cycles an owner keeps the display once granted; must be >= 1.
- BLINK_CYCLES, 25_000_000, half-period of the src2 blink; must be >= 1.
- IDLE_VAL, 16'h0000, value driven when no source owns the display.

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous active-high reset
- req  in  3  per-source request; req[k] high = source k wants the display
- val0  in  16  src0 value, 4 hex nibbles, [3:0] = rightmost digit
- val1  in  16  src1 value
- val2  in  16  src2 value
- gnt  out  3  one-hot grant; all zero when idle
- disp_src  out  2  current owner: 0, 1, 2; 3 = none
- x  out  16  value to the display decoder
- disp_on  out  1  1 = segments enabled; 0 = blanked (blink off-phase)

Behaviour:
- Reset (clr high, asynchronous):
  - gnt=0, disp_src=3, x=IDLE_VAL, disp_on=1.
  - Internal hold and blink counters = 0; state IDLE.
- All outputs are registered.
- State is the owner register {IDLE, OWN0, OWN1, OWN2}.
- hp = highest-priority asserted req bit; none if req=0.
- hold_cnt is loaded with HOLD_CYCLES-1 on every grant change into an OWNk state. It decrements each cycle while nonzero. "Hold expired" means hold_cnt==0.
- Transitions are evaluated every cycle, from owner k:
  - req[k] dropped: move to hp next cycle, or IDLE if none. Hold is ignored.
  - req[k] held, hp higher than k, hold expired: move to OWNhp.
  - req[k] held, hp higher than k, hold not expired: stay. The request is deferred, not lost; it is re-evaluated every cycle.
  - Lower-priority requests never preempt.
- From IDLE: move to OWNhp on the first cycle any req is high.
- Grant latency: req rising edge at cycle n gives gnt/disp_src update at edge n+1, when arbitration permits.
- x tracks the owner's value live: x <= val[owner] every cycle, with 1-cycle latency. In IDLE, x <= IDLE_VAL.
- On an owner change, x switches to the new source's value in the same cycle gnt changes. There is never a cycle showing the new gnt with the old source's data.
- Blink:
  - While owner is OWN2, blink_cnt counts 0..BLINK_CYCLES-1 and wraps. disp_on toggles at each wrap.
  - Entering OWN2: blink_cnt=0, disp_on=1.
  - Any other state: disp_on=1 and blink_cnt held at 0.
- Simultaneous events:
  - Owner drop and new request in the same cycle: the drop rule wins and hp is chosen immediately.
  - Several new requests: the highest priority wins.
- Re-grant: if the owner drops and re-asserts with no other request, it is re-granted through IDLE. That costs 1 IDLE cycle, then hold is reloaded.
- clr mid-operation: immediate return to reset values; in-flight hold and blink state are discarded.
- Counter widths are sized by $clog2 of the parameters; no overflow is possible.

Test Plan:
- Reset then idle: assert clr, release, req=0 for 10 cycles -> gnt=000, disp_src=3, x=16'h0000, disp_on=1 throughout.
- Basic grant, with HOLD_CYCLES=8: req=001 with val0=16'h1234 -> gnt=001 and x=16'h1234 one cycle later. Change val0 to 16'h1235 -> x follows next cycle.
- Preemption respects hold, with HOLD_CYCLES=8: src0 granted at cycle t, req[2] raised at t+2 with val2=16'hEEEE -> gnt stays 001 until hold expires, then gnt=100 and x=16'hEEEE at t+8. src1 raised meanwhile is ignored while src2 holds.
- Owner drop bypasses hold: src1 owner, req[1] falls at cycle 2 of hold while req[0]=1 -> gnt=001 and x=val0 on the next edge.
- Blink, with BLINK_CYCLES=4: src2 owns for 20 cycles -> disp_on pattern 1111 0000 1111 ... On release, disp_on=1 in the same cycle gnt leaves 100.
- Async reset mid-hold: clr pulsed between clock edges while OWN2 is in its blink off-phase -> outputs return to reset values immediately, without waiting for clk. After release with req=100, the bench sees a fresh grant with disp_on=1.
